// File: rtl/seq_gen_1011.sv
// Serial frame transmitter: sends MARKER (bit 3 first) then the payload MSB first, one bit per clock.
// Optional even-parity trailer bit is enabled by defining SEQ_GEN_PARITY_EN.
module seq_gen_1011 #(
   parameter int         PAYLOAD_W = 8,
   parameter logic [3:0] MARKER    = 4'b1011
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [PAYLOAD_W-1:0] in_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic                 out_bit,
   output logic                 out_valid,
   output logic                 busy,
   output logic                 frame_done
);

   localparam int MAXW = (PAYLOAD_W > 4) ? PAYLOAD_W : 4;
   localparam int CW   = $clog2(MAXW) + 1;
`ifdef SEQ_GEN_PARITY_EN
   localparam int SW   = PAYLOAD_W + 4;
`else
   localparam int SW   = PAYLOAD_W + 3;
`endif

   typedef enum logic [1:0] {
      IDLE,
      SYNC,
      DATA
`ifdef SEQ_GEN_PARITY_EN
      , PARITY
`endif
   } state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [SW-1:0]   shreg_q, shreg_d, frame_w;
   logic            out_bit_q, out_bit_d;
   logic            out_valid_q, out_valid_d;
   logic            done_q, done_d;
   logic            last_bit, accept;

   // Everything after the first marker bit is preloaded so every later step is a plain shift.
`ifdef SEQ_GEN_PARITY_EN
   assign frame_w  = {MARKER[2:0], in_data, ^in_data};
   assign last_bit = (state_q == PARITY);
`else
   assign frame_w  = {MARKER[2:0], in_data};
   assign last_bit = (state_q == DATA) && (cnt_q == '0);
`endif

   assign in_ready   = reset && ((state_q == IDLE) || last_bit);
   assign accept     = in_valid && in_ready;
   assign out_bit    = out_bit_q;
   assign out_valid  = out_valid_q;
   assign busy       = (state_q != IDLE);
   assign frame_done = done_q;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      shreg_d     = shreg_q;
      out_bit_d   = 1'b0;
      out_valid_d = 1'b0;
      if (accept) begin
         state_d     = SYNC;
         cnt_d       = CW'(3);
         shreg_d     = frame_w;
         out_bit_d   = MARKER[3];
         out_valid_d = 1'b1;
      end else begin
         case (state_q)
            IDLE: ;
            SYNC: begin
               out_valid_d = 1'b1;
               out_bit_d   = shreg_q[SW-1];
               shreg_d     = shreg_q << 1;
               if (cnt_q == '0) begin
                  state_d = DATA;
                  cnt_d   = CW'(PAYLOAD_W - 1);
               end else begin
                  cnt_d = cnt_q - CW'(1);
               end
            end
            DATA: begin
               if (cnt_q != '0) begin
                  out_valid_d = 1'b1;
                  out_bit_d   = shreg_q[SW-1];
                  shreg_d     = shreg_q << 1;
                  cnt_d       = cnt_q - CW'(1);
               end else begin
`ifdef SEQ_GEN_PARITY_EN
                  state_d     = PARITY;
                  out_valid_d = 1'b1;
                  out_bit_d   = shreg_q[SW-1];
                  shreg_d     = shreg_q << 1;
`else
                  state_d     = IDLE;
`endif
                  cnt_d       = '0;
               end
            end
`ifdef SEQ_GEN_PARITY_EN
            PARITY: state_d = IDLE;
`endif
            default: state_d = IDLE;
         endcase
      end
      // frame_done is registered, so flag the bit about to be presented.
`ifdef SEQ_GEN_PARITY_EN
      done_d = (state_d == PARITY);
`else
      done_d = (state_d == DATA) && (cnt_d == '0);
`endif
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         shreg_q     <= '0;
         out_bit_q   <= 1'b0;
         out_valid_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         shreg_q     <= shreg_d;
         out_bit_q   <= out_bit_d;
         out_valid_q <= out_valid_d;
         done_q      <= done_d;
      end
   end

endmodule
